// File: rtl/swap_restore_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swap_pkg
// Description : Shared types and helpers for the SWAP restore sequencer:
//               register index / mapping-table types, FSM state encoding,
//               the swap update rule and an identity test.
// Revision    : 1.0 - initial release
// ============================================================================
package swap_pkg;

  localparam int NREG  = 4;
  localparam int IDX_W = $clog2(NREG);

  typedef logic [IDX_W-1:0] idx_t;

  // map[i] = physical register currently holding logical register i
  typedef idx_t [NREG-1:0] map_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Same exchange the mapper performs; a == b leaves the table unchanged.
  function automatic map_t apply_swap(input map_t m, input idx_t a, input idx_t b);
    map_t r;
    r    = m;
    r[a] = m[b];
    r[b] = m[a];
    return r;
  endfunction

  function automatic logic map_is_identity(input map_t m);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (m[i] != idx_t'(i)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swap_restore_seq_find.sv
`default_nettype none
// ============================================================================
// Module      : map_inverse_find
// Description : Combinational inverse lookup: returns the position j whose
//               table entry equals target. The table is a permutation, so
//               exactly one position matches.
// Ports       : map    - shadow mapping table
//               target - value to locate
//               pos    - index j with map[j] == target
// Revision    : 1.0 - initial release
// ============================================================================
module map_inverse_find
  import swap_pkg::*;
(
  input  map_t map,
  input  idx_t target,
  output idx_t pos
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < NREG; i++) begin
      if (map[i] == target) pos = idx_t'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/swap_restore_seq.sv
`default_nettype none
// ============================================================================
// Module      : swap_restore_seq
// Description : Snoops core SWAPs into a shadow mapping table and, on
//               request, issues the minimal SWAP sequence that returns the
//               register mapper to identity.
// Ports       : clk, reset (sync, active-low)
//               snoop_swap/snoop_reg1/snoop_reg2 - SWAP executed by the core
//               restore_req                      - start restore (IDLE only)
//               swp_valid/swp_reg1/swp_reg2      - SWAP command to mapper mux
//               swp_ready                        - mapper accepted command
//               busy        - restore in progress (SCAN or EMIT)
//               done        - one-cycle pulse when identity is reached
//               is_identity - shadow table is identity (registered)
//               proto_err   - sticky: snoop seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module swap_restore_seq
  import swap_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             snoop_swap,
  input  logic [IDX_W-1:0] snoop_reg1,
  input  logic [IDX_W-1:0] snoop_reg2,
  input  logic             restore_req,
  output logic             swp_valid,
  output logic [IDX_W-1:0] swp_reg1,
  output logic [IDX_W-1:0] swp_reg2,
  input  logic             swp_ready,
  output logic             busy,
  output logic             done,
  output logic             is_identity,
  output logic             proto_err
);

  localparam idx_t LAST_IDX = idx_t'(NREG - 2);

  state_t state, state_nx;
  idx_t   idx, idx_nx;
  map_t   map, map_nx;
  logic   swp_valid_nx;
  idx_t   swp_reg1_nx, swp_reg2_nx;
  logic   proto_err_nx;
  idx_t   find_pos;

  map_inverse_find u_find (
    .map    (map),
    .target (idx),
    .pos    (find_pos)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      for (int i = 0; i < NREG; i++) map[i] <= idx_t'(i);
      swp_valid   <= 1'b0;
      swp_reg1    <= '0;
      swp_reg2    <= '0;
      proto_err   <= 1'b0;
      is_identity <= 1'b1;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      map         <= map_nx;
      swp_valid   <= swp_valid_nx;
      swp_reg1    <= swp_reg1_nx;
      swp_reg2    <= swp_reg2_nx;
      proto_err   <= proto_err_nx;
      // Computed from the table being loaded, so it tracks the update edge.
      is_identity <= map_is_identity(map_nx);
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    map_nx       = map;
    swp_valid_nx = swp_valid;
    swp_reg1_nx  = swp_reg1;
    swp_reg2_nx  = swp_reg2;
    proto_err_nx = proto_err;

    case (state)
      IDLE: begin
        // Snoop is applied in the same cycle as a restore request, so the
        // first SCAN already sees the updated table.
        if (snoop_swap) map_nx = apply_swap(map, snoop_reg1, snoop_reg2);
        if (restore_req) begin
          state_nx = SCAN;
          idx_nx   = '0;
        end
      end

      SCAN: begin
        if (snoop_swap) proto_err_nx = 1'b1;
        if (map[idx] == idx) begin
          // The last entry is forced correct once all lower ones are.
          if (idx == LAST_IDX) state_nx = DONE;
          else                 idx_nx   = idx + idx_t'(1);
        end else begin
          swp_valid_nx = 1'b1;
          swp_reg1_nx  = idx;
          swp_reg2_nx  = find_pos;
          state_nx     = EMIT;
        end
      end

      EMIT: begin
        if (snoop_swap) proto_err_nx = 1'b1;
        if (swp_ready) begin
          map_nx       = apply_swap(map, swp_reg1, swp_reg2);
          swp_valid_nx = 1'b0;
          if (idx == LAST_IDX) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + idx_t'(1);
            state_nx = SCAN;
          end
        end
      end

      DONE: begin
        if (snoop_swap) map_nx = apply_swap(map, snoop_reg1, snoop_reg2);
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state == SCAN) || (state == EMIT);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_swap_restore_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_swap_restore_seq
// Description : Directed self-checking bench for swap_restore_seq (NREG=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_restore_seq;
  import swap_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       snoop_swap;
  logic [1:0] snoop_reg1, snoop_reg2;
  logic       restore_req;
  logic       swp_valid;
  logic [1:0] swp_reg1, swp_reg2;
  logic       swp_ready;
  logic       busy, done, is_identity, proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  swap_restore_seq dut (
    .clk         (clk),
    .reset       (reset),
    .snoop_swap  (snoop_swap),
    .snoop_reg1  (snoop_reg1),
    .snoop_reg2  (snoop_reg2),
    .restore_req (restore_req),
    .swp_valid   (swp_valid),
    .swp_reg1    (swp_reg1),
    .swp_reg2    (swp_reg2),
    .swp_ready   (swp_ready),
    .busy        (busy),
    .done        (done),
    .is_identity (is_identity),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // busy / done / swp_valid together
  task automatic chk_st(input string tag, input logic b, input logic d, input logic v);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".valid"}, {31'd0, swp_valid}, {31'd0, v});
  endtask

  task automatic chk_cmd(input string tag, input logic [1:0] r1, input logic [1:0] r2);
    chk({tag, ".valid"}, {31'd0, swp_valid}, 32'd1);
    chk({tag, ".reg1"}, {30'd0, swp_reg1}, {30'd0, r1});
    chk({tag, ".reg2"}, {30'd0, swp_reg2}, {30'd0, r2});
  endtask

  task automatic snoop(input logic [1:0] a, input logic [1:0] b);
    snoop_swap = 1'b1;
    snoop_reg1 = a;
    snoop_reg2 = b;
    tick();
    snoop_swap = 1'b0;
  endtask

  // Shadow table must always be a permutation of 0..NREG-1.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int v = 0; v < NREG; v++) begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < NREG; i++)
          if (dut.map[i] == idx_t'(v)) cnt++;
        n_checks++;
        assert (cnt == 1) else begin
          n_fail++;
          $error("FAIL perm: value %0d occurs %0d times, required 1", v, cnt);
        end
      end
    end
  end

  initial begin
    reset       = 1'b0;
    snoop_swap  = 1'b0;
    snoop_reg1  = '0;
    snoop_reg2  = '0;
    restore_req = 1'b0;
    swp_ready   = 1'b0;
    tick();
    tick();

    // Reset state
    chk_st("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.reg1", {30'd0, swp_reg1}, 32'd0);
    chk("rst.reg2", {30'd0, swp_reg2}, 32'd0);
    chk("rst.ident", {31'd0, is_identity}, 32'd1);
    chk("rst.perr", {31'd0, proto_err}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: restore of identity table: 3 SCAN cycles, no SWAPs, then done
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    chk_st("s1.scan0", 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("s1.scan1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("s1.scan2", 1'b1, 1'b0, 1'b0);
    chk("s1.ident", {31'd0, is_identity}, 32'd1);
    tick();
    chk_st("s1.done", 1'b0, 1'b1, 1'b0);
    tick();
    chk_st("s1.idle", 1'b0, 1'b0, 1'b0);

    // 2: table [1,2,0,3], ready always high -> (0,2) then (1,2)
    snoop(2'd0, 2'd1);
    snoop(2'd1, 2'd2);
    chk("s2.ident_pre", {31'd0, is_identity}, 32'd0);
    swp_ready   = 1'b1;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    chk_st("s2.scan0", 1'b1, 1'b0, 1'b0);
    tick();
    chk_cmd("s2.cmd0", 2'd0, 2'd2);
    tick();
    chk_st("s2.scan1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_cmd("s2.cmd1", 2'd1, 2'd2);
    tick();
    chk_st("s2.scan2", 1'b1, 1'b0, 1'b0);
    chk("s2.ident_post", {31'd0, is_identity}, 32'd1);
    tick();
    chk_st("s2.done", 1'b0, 1'b1, 1'b0);
    tick();
    chk_st("s2.idle", 1'b0, 1'b0, 1'b0);

    // 3: same table, first command stalled 5 cycles
    swp_ready = 1'b0;
    snoop(2'd0, 2'd1);
    snoop(2'd1, 2'd2);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_cmd($sformatf("s3.hold%0d", k), 2'd0, 2'd2);
      tick();
    end
    chk_cmd("s3.hold5", 2'd0, 2'd2);
    swp_ready = 1'b1;
    tick();
    chk_st("s3.scan1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_cmd("s3.cmd1", 2'd1, 2'd2);
    tick();
    chk_st("s3.scan2", 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("s3.done", 1'b0, 1'b1, 1'b0);
    chk("s3.ident", {31'd0, is_identity}, 32'd1);
    tick();

    // 4: (3,3) is a no-op, (2,3) gives [0,1,3,2] -> single SWAP (2,3)
    snoop(2'd3, 2'd3);
    chk("s4.ident_noop", {31'd0, is_identity}, 32'd1);
    snoop(2'd2, 2'd3);
    chk("s4.ident_pre", {31'd0, is_identity}, 32'd0);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick();
    tick();
    chk_st("s4.scan2", 1'b1, 1'b0, 1'b0);
    tick();
    chk_cmd("s4.cmd", 2'd2, 2'd3);
    tick();
    chk_st("s4.done", 1'b0, 1'b1, 1'b0);
    chk("s4.ident", {31'd0, is_identity}, 32'd1);
    tick();

    // 5: snoop + restore_req during EMIT -> proto_err, shadow untouched
    swp_ready = 1'b0;
    snoop(2'd0, 2'd1);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick();
    chk_cmd("s5.cmd", 2'd0, 2'd1);
    snoop_swap  = 1'b1;
    snoop_reg1  = 2'd2;
    snoop_reg2  = 2'd3;
    restore_req = 1'b1;
    tick();
    snoop_swap  = 1'b0;
    restore_req = 1'b0;
    chk("s5.perr", {31'd0, proto_err}, 32'd1);
    chk_cmd("s5.cmd_hold", 2'd0, 2'd1);
    swp_ready = 1'b1;
    tick();
    tick();
    tick();
    chk_st("s5.done", 1'b0, 1'b1, 1'b0);
    chk("s5.ident", {31'd0, is_identity}, 32'd1);
    tick();
    chk_st("s5.idle", 1'b0, 1'b0, 1'b0);
    chk("s5.perr_sticky", {31'd0, proto_err}, 32'd1);

    // 6: reset while EMIT -> abort, identity table, no done
    swp_ready = 1'b0;
    snoop(2'd0, 2'd1);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick();
    chk_cmd("s6.cmd", 2'd0, 2'd1);
    reset = 1'b0;
    tick();
    chk_st("s6.rst", 1'b0, 1'b0, 1'b0);
    chk("s6.ident", {31'd0, is_identity}, 32'd1);
    chk("s6.perr", {31'd0, proto_err}, 32'd0);
    reset = 1'b1;
    tick();
    chk_st("s6.after", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swap_restore_seq.md
Name: swap_restore_seq

Overview:
- Initiator counterpart of the register-mapping (SWAP) unit: issues SWAP commands instead of receiving them.
- Snoops every SWAP the core executes and keeps a shadow copy of the logical-to-physical mapping table.
- On a restore request, emits the minimal SWAP sequence that returns the mapping unit to identity (logical i -> physical i).
- Used before halt, context switch or debug readout; its SWAP commands are muxed onto the mapper's swap port while the core is stalled.

Parameters:
- NREG, 4, number of architectural registers (>= 2).
- IDX_W, $clog2(NREG), register index width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- snoop_swap  input  1  core executed a SWAP this cycle
- snoop_reg1  input  IDX_W  first operand of the snooped SWAP
- snoop_reg2  input  IDX_W  second operand of the snooped SWAP
- restore_req  input  1  start-restore request (level sampled in IDLE)
- swp_valid  output  1  SWAP command valid toward mapper mux
- swp_reg1  output  IDX_W  SWAP operand 1
- swp_reg2  output  IDX_W  SWAP operand 2
- swp_ready  input  1  mapper accepted the command this cycle
- busy  output  1  restore in progress (states SCAN or EMIT)
- done  output  1  one-cycle pulse when the mapping is identity again
- is_identity  output  1  shadow table equals identity (registered)
- proto_err  output  1  sticky: snoop_swap seen while busy

Behaviour:
- Clock and reset: clk; reset is synchronous and active-low.
- Reset state:
  - shadow map[i] = i.
  - state = IDLE, idx = 0.
  - swp_valid = 0, swp_reg1 = 0, swp_reg2 = 0.
  - busy = 0, done = 0, is_identity = 1, proto_err = 0.
  - Reset asserted mid-restore aborts the restore at that edge; no done pulse is produced.
- Shadow update rule, for both snooped and accepted SWAPs:
  - new map[r1] = old map[r2]; new map[r2] = old map[r1]. This is the same semantics as the mapper.
  - r1 == r2 leaves the table unchanged.
- Snoop:
  - In IDLE or DONE, snoop_swap=1 applies the update at the clock edge.
  - In SCAN or EMIT, the snoop is ignored and proto_err is set. proto_err is cleared only by reset.
- is_identity is recomputed from the next-state table every cycle, so it is valid one cycle after any update.
- States:
  - IDLE: restore_req=1 -> SCAN with idx=0. A snoop in the same cycle is applied first; SCAN reads the updated table.
  - SCAN: one index per cycle.
    - If map[idx]==idx: idx==NREG-2 -> DONE, else idx++.
    - Otherwise, find the unique j>idx with map[j]==idx. Register swp_reg1=idx, swp_reg2=j, swp_valid=1, then -> EMIT.
  - EMIT:
    - Hold swp_valid, swp_reg1 and swp_reg2 stable until swp_ready=1.
    - On handshake: apply the swap to the shadow table and drop swp_valid at that edge. Then idx==NREG-2 -> DONE, else idx++ and -> SCAN.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- restore_req is ignored outside IDLE.
- At most NREG-1 SWAPs are emitted per restore.
- Each index costs 1 cycle when already correct, or 1 + wait cycles when a SWAP is needed.
- An already-identity table completes with zero SWAPs: NREG-1 SCAN cycles, then the done pulse.
- busy = (state==SCAN || state==EMIT).
- swp_valid is never asserted outside EMIT.
- swp_ready received while swp_valid=0 is ignored.
- The search for j must never miss: the shadow table is always a permutation. An assertion in the bench checks this.

Decomposition:
- Package swap_pkg:
  - NREG, IDX_W.
  - typedef idx_t (logic [IDX_W-1:0]).
  - typedef map_t (idx_t array [NREG]).
  - enum state_t {IDLE, SCAN, EMIT, DONE}.
- Sub-module map_inverse_find: combinational; inputs map_t and target idx_t; outputs the position j.
- The FSM, shadow table and handshake stay in swap_restore_seq.

Test Plan:
1. Reset, then restore_req=1 with no prior snoops -> no swp_valid; done pulses after 3 SCAN cycles (NREG=4); is_identity=1 throughout.
2. Snoop swaps (0,1) then (1,2), so the table is [1,2,0,3]. Then restore_req with swp_ready=1 -> emits (0,2) then (1,2); done pulses; is_identity=1.
3. Same as scenario 2 but swp_ready held 0 for 5 cycles on the first command -> swp_valid, swp_reg1=0 and swp_reg2=2 stay stable all 5 cycles; the sequence then completes as in scenario 2.
4. Snoop swap (3,3), then (2,3) -> table [0,1,3,2], is_identity=0. Restore -> single SWAP (2,3) emitted; done pulses.
5. During EMIT, snoop_swap=1 and restore_req=1 -> proto_err=1 (sticky), shadow unchanged, restore finishes normally.
6. Drive reset=0 while in EMIT with swp_valid=1 -> next cycle swp_valid=0, busy=0, table identity, no done pulse.
